mem_bus_responder: RTL

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_responder
//  Function : Single-port word memory behind a req/ack bus with fixed wait
//             latency, alignment/range error reporting and optional byte
//             enables (macro MEM_BUS_RESPONDER_BYTE_EN adds port be).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
`ifdef MEM_BUS_RESPONDER_BYTE_EN
    input  logic [3:0]  be,
`endif
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err
);

    localparam int         c_AW       = $clog2(DEPTH);
    localparam logic [3:0] c_CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state_q, w_state_d;
    logic [3:0]        r_cnt_q,   w_cnt_d;
    logic [31:0]       r_addr_q,  w_addr_d;
    logic              r_we_q,    w_we_d;
    logic [31:0]       r_wdata_q, w_wdata_d;
    logic [31:0]       r_rdata_q, w_rdata_d;
    logic [31:0]       r_mem_q [DEPTH];
    logic [c_AW-1:0]   w_idx;
    logic              w_enter_resp;
    logic              w_bad_d;
    logic              w_mem_wr;
    logic [31:0]       w_wr_word;
`ifdef MEM_BUS_RESPONDER_BYTE_EN
    logic [3:0]        r_be_q,    w_be_d;
`endif

    function automatic logic f_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:c_AW+2] != '0);
    endfunction

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_addr_d  = r_addr_q;
        w_we_d    = r_we_q;
        w_wdata_d = r_wdata_q;
`ifdef MEM_BUS_RESPONDER_BYTE_EN
        w_be_d    = r_be_q;
`endif
        case (r_state_q)
            IDLE: begin
                if (req) begin
                    w_addr_d  = addr;
                    w_we_d    = we;
                    w_wdata_d = wdata;
`ifdef MEM_BUS_RESPONDER_BYTE_EN
                    w_be_d    = be;
`endif
                    if (LATENCY == 0) begin
                        w_state_d = RESP;
                    end else begin
                        w_state_d = WAIT;
                        w_cnt_d   = c_CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    w_state_d = RESP;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            RESP:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // Memory access happens on the edge entering RESP, so it uses the
    // next-state copies of the latched fields (valid even when LATENCY=0).
    always_comb begin
        w_enter_resp = (w_state_d == RESP) && (r_state_q != RESP);
        w_idx        = w_addr_d[c_AW+1:2];
        w_bad_d      = f_bad(w_addr_d);
        w_rdata_d    = r_rdata_q;
        if (w_enter_resp && !w_we_d) begin
            w_rdata_d = w_bad_d ? 32'h0 : r_mem_q[w_idx];
        end
        w_wr_word = w_wdata_d;
`ifdef MEM_BUS_RESPONDER_BYTE_EN
        for (int i = 0; i < 4; i++) begin
            w_wr_word[8*i +: 8] = w_be_d[i] ? w_wdata_d[8*i +: 8] : r_mem_q[w_idx][8*i +: 8];
        end
        w_mem_wr = w_enter_resp && w_we_d && !w_bad_d && (w_be_d != 4'b0000);
`else
        w_mem_wr = w_enter_resp && w_we_d && !w_bad_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= IDLE;
            r_cnt_q   <= 4'd0;
            r_rdata_q <= 32'h0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_rdata_q <= w_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        r_addr_q  <= w_addr_d;
        r_we_q    <= w_we_d;
        r_wdata_q <= w_wdata_d;
`ifdef MEM_BUS_RESPONDER_BYTE_EN
        r_be_q    <= w_be_d;
`endif
    end

    // Contents survive reset; a reset edge only suppresses the pending write.
    always_ff @(posedge clk) begin
        if (!reset && w_mem_wr) begin
            r_mem_q[w_idx] <= w_wr_word;
        end
    end

    assign ack   = (r_state_q == RESP);
    assign err   = ack && f_bad(r_addr_q);
    assign rdata = r_rdata_q;

endmodule
`default_nettype wire
